// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Program-counter register and next-PC selector with an instruction-fetch
//   handshake. It holds one pending redirect while a fetch is outstanding or
//   the pipeline is stalled.
//
//   Optional feature macro: PC_MISALIGN_TRAP_EN
//     defined   : a register-jump target with [1:0] != 0 loads TRAP_VECTOR,
//                 and trap pulses for one cycle together with the advance.
//     undefined : reg_tgt[1:0] is forced to 00 before use, and trap is tied 0.
//
// Ports
//   clk            in   1   clock, rising edge
//   clrn           in   1   asynchronous active-low reset
//   pcsrc          in   2   00 pc+4, 01 branch, 10 register jump, 11 pseudo-direct jump
//   redirect_valid in   1   pcsrc/targets valid this cycle
//   branch_off     in   32  sign-extended branch offset, already shifted left by 2
//   jump_tgt       in   32  pseudo-direct jump target, already formed
//   reg_tgt        in   32  register jump target
//   stall          in   1   downstream cannot accept a new instruction
//   imem_ack       in   1   instruction memory returned data for imem_addr
//   imem_req       out  1   fetch request
//   imem_addr      out  32  fetch address (== pc)
//   pc             out  32  current pc
//   pcadd4         out  32  pc + 4, modulo 2^32
//   fetch_valid    out  1   instruction for pc is available to decode
//   fetch_err      out  1   sticky fetch-timeout flag
//   trap           out  1   misaligned-target pulse
//
// State    | meaning
// ---------+----------------------------------------------------------------
// S_BOOT   | first cycle after reset; no request
// S_FETCH  | request outstanding for pc; an ack with no stall advances pc
// S_STALL  | instruction for pc is held for decode; waiting for stall to drop
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0008,
    parameter int          TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [1:0]  pcsrc,
    input  logic        redirect_valid,
    input  logic [31:0] branch_off,
    input  logic [31:0] jump_tgt,
    input  logic [31:0] reg_tgt,
    input  logic        stall,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pcadd4,
    output logic        fetch_valid,
    output logic        fetch_err,
    output logic        trap
);

    localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   pc_q;
    logic          pend_valid;
    logic [31:0]   pend_tgt;
    logic [CW-1:0] tmo_cnt;
    logic          fetch_err_q;

    logic          advance;
    logic          redir_hit;
    logic [31:0]   reg_tgt_use;
    logic [31:0]   redir_tgt;
    logic [31:0]   sel_tgt;
    logic [31:0]   next_pc;

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign pcadd4    = pc_q + 32'd4;
    assign fetch_err = fetch_err_q;

    // pcsrc=00 with redirect_valid is the fall-through case, not a redirect.
    assign redir_hit = redirect_valid && (pcsrc != 2'b00);

`ifdef PC_MISALIGN_TRAP_EN
    logic pend_reg;
    logic sel_reg;
    logic misalign;

    assign reg_tgt_use = reg_tgt;
`else
    logic unused_reg_low;

    assign unused_reg_low = ^reg_tgt[1:0];
    assign reg_tgt_use    = {reg_tgt[31:2], 2'b00};
`endif

    always_comb begin
        redir_tgt = pcadd4;
        case (pcsrc)
            2'b01:   redir_tgt = pcadd4 + branch_off;
            2'b10:   redir_tgt = reg_tgt_use;
            2'b11:   redir_tgt = jump_tgt;
            default: redir_tgt = pcadd4;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        fetch_valid = 1'b0;
        advance     = 1'b0;
        case (state)
            S_BOOT: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    fetch_valid = 1'b1;
                    if (stall) begin
                        state_nxt = S_STALL;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_STALL: begin
                fetch_valid = 1'b1;
                if (!stall) begin
                    advance   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_BOOT;
            end
        endcase
    end

    // A redirect arriving in the advance cycle beats an older pending one.
`ifdef PC_MISALIGN_TRAP_EN
    always_comb begin
        sel_tgt = pcadd4;
        sel_reg = 1'b0;
        if (redir_hit) begin
            sel_tgt = redir_tgt;
            sel_reg = (pcsrc == 2'b10);
        end else if (pend_valid) begin
            sel_tgt = pend_tgt;
            sel_reg = pend_reg;
        end
    end

    assign misalign = sel_reg && (sel_tgt[1:0] != 2'b00);
    assign next_pc  = misalign ? TRAP_VECTOR : sel_tgt;
    assign trap     = advance && misalign;
`else
    always_comb begin
        sel_tgt = pcadd4;
        if (redir_hit) begin
            sel_tgt = redir_tgt;
        end else if (pend_valid) begin
            sel_tgt = pend_tgt;
        end
    end

    assign next_pc = sel_tgt;
    assign trap    = 1'b0;
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= S_BOOT;
            pc_q  <= RESET_VECTOR;
        end else begin
            state <= state_nxt;
            if (advance) begin
                pc_q <= next_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pend_valid <= 1'b0;
            pend_tgt   <= 32'h0;
        end else if (advance) begin
            pend_valid <= 1'b0;
        end else if (redir_hit) begin
            pend_valid <= 1'b1;
            pend_tgt   <= redir_tgt;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pend_reg <= 1'b0;
        end else if (!advance && redir_hit) begin
            pend_reg <= (pcsrc == 2'b10);
        end
    end
`endif

    // Timeout counter saturates at its last value; the request keeps going after the error.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            tmo_cnt     <= '0;
            fetch_err_q <= 1'b0;
        end else if (state == S_FETCH) begin
            if (imem_ack) begin
                tmo_cnt <= '0;
            end else begin
                if (tmo_cnt == TMO_LAST) begin
                    fetch_err_q <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule
